// File: rtl/e2prom_rw_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// e2prom_pkg : state encoding, bus direction constants and test pattern
// Rev 1.0
// ============================================================================
package e2prom_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WR_REQ  = 3'd1;
  localparam state_t S_WR_WAIT = 3'd2;
  localparam state_t S_WR_GAP  = 3'd3;
  localparam state_t S_RD_REQ  = 3'd4;
  localparam state_t S_RD_WAIT = 3'd5;
  localparam state_t S_ABORT   = 3'd6;
  localparam state_t S_FINISH  = 3'd7;

  localparam logic WL_WRITE = 1'b0;
  localparam logic WL_READ  = 1'b1;

  // Byte k of a run carries (seed + k) mod 256
  function automatic logic [7:0] expected_byte(input logic [7:0] seed, input logic [8:0] k);
    return 8'(seed + k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/e2prom_rw_ctrl_if.sv
`default_nettype none
// ============================================================================
// e2prom_rw_ctrl_if : request/response bus between the controller and i2c_dri
// Rev 1.0
// ============================================================================
interface e2prom_rw_ctrl_if;

  logic        i2c_trigger;
  logic        i2c_wl_rh;
  logic        i2c_addr_width;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_wr_data;
  logic        i2c_done;
  logic [7:0]  i2c_rd_data;

  modport master (
    output i2c_trigger, i2c_wl_rh, i2c_addr_width, i2c_addr, i2c_wr_data,
    input  i2c_done, i2c_rd_data
  );

  modport slave (
    input  i2c_trigger, i2c_wl_rh, i2c_addr_width, i2c_addr, i2c_wr_data,
    output i2c_done, i2c_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/e2prom_rw_ctrl_dly_cnt.sv
`default_nettype none
// ============================================================================
// e2prom_dly_cnt : loadable down-counter that parks at zero
// Rev 1.0
// ============================================================================
module e2prom_dly_cnt #(
  parameter int WIDTH = 8
) (
  input  wire logic             sys_clk,
  input  wire logic             sys_rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/e2prom_rw_ctrl.sv
`default_nettype none
// ============================================================================
// e2prom_rw_ctrl : writes a seeded pattern to an EEPROM via i2c_dri, reads it
//                  back and reports pass/fail/timeout. Rev 1.0
// ============================================================================
module e2prom_rw_ctrl
  import e2prom_pkg::*;
#(
  parameter int          SYS_CLK     = 50_000_000,
  parameter int          BYTE_NUM    = 16,
  parameter logic [15:0] START_ADDR  = 16'h0000,
  parameter logic        ADDR_16BIT  = 1'b0,
  parameter int          WR_GAP_CYC  = 250_000,
  parameter int          TIMEOUT_CYC = 2_000_000
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst_n,
  input  wire logic        start,
  input  wire logic [7:0]  seed,
  e2prom_rw_ctrl_if.master i2c,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [15:0]      err_addr,
  output logic [7:0]       err_data
);

  localparam int          GAP_W  = (WR_GAP_CYC  > 1) ? $clog2(WR_GAP_CYC + 1)  : 1;
  localparam int          TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [8:0]  K_LAST = 9'(BYTE_NUM - 1);

  state_t      r_state;
  logic [8:0]  r_k;
  logic [7:0]  r_seed;
  logic [15:0] r_addr;
  logic [7:0]  r_wr_data;
  logic        r_wl_rh;
  logic        r_busy;
  logic        r_pass;
  logic        r_fail;
  logic        r_timeout;
  logic [15:0] r_err_addr;
  logic [7:0]  r_err_data;

  logic        w_req;
  logic        w_gap_load;
  logic        w_gap_zero;
  logic        w_to_zero;
  logic        w_rd_ok;
  logic [8:0]  w_k_next;
  logic [15:0] w_addr_next;

  assign w_req       = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
  assign w_gap_load  = (r_state == S_WR_WAIT) && i2c.i2c_done;
  assign w_k_next    = r_k + 9'd1;
  assign w_addr_next = START_ADDR + 16'(w_k_next);
  assign w_rd_ok     = (i2c.i2c_rd_data == expected_byte(r_seed, r_k));

  e2prom_dly_cnt #(.WIDTH(GAP_W)) u_gap_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (w_gap_load),
    .load_val  (GAP_W'(WR_GAP_CYC)),
    .zero      (w_gap_zero)
  );

  // Reloaded on every request, so it bounds each trigger-to-done window
  e2prom_dly_cnt #(.WIDTH(TO_W)) u_to_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (w_req),
    .load_val  (TO_W'(TIMEOUT_CYC)),
    .zero      (w_to_zero)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_seed     <= '0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_wl_rh    <= WL_WRITE;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_addr <= '0;
      r_err_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed     <= seed;
            r_k        <= '0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err_addr <= '0;
            r_err_data <= '0;
            r_busy     <= 1'b1;
            r_addr     <= START_ADDR;
            r_wr_data  <= seed;
            r_wl_rh    <= WL_WRITE;
            r_state    <= S_WR_REQ;
          end
        end
        S_WR_REQ: r_state <= S_WR_WAIT;
        S_WR_WAIT: begin
          // done has priority over an expiring timeout in the same cycle
          if (i2c.i2c_done) begin
            r_state <= S_WR_GAP;
          end else if (w_to_zero) begin
            r_state <= S_ABORT;
          end
        end
        S_WR_GAP: begin
          if (w_gap_zero) begin
            if (r_k == K_LAST) begin
              r_k     <= '0;
              r_addr  <= START_ADDR;
              r_wl_rh <= WL_READ;
              r_state <= S_RD_REQ;
            end else begin
              r_k       <= w_k_next;
              r_addr    <= w_addr_next;
              r_wr_data <= expected_byte(r_seed, w_k_next);
              r_state   <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (i2c.i2c_done) begin
            if (!w_rd_ok) begin
              r_err_addr <= r_addr;
              r_err_data <= i2c.i2c_rd_data;
              r_fail     <= 1'b1;
              r_state    <= S_FINISH;
            end else if (r_k == K_LAST) begin
              r_pass  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_k     <= w_k_next;
              r_addr  <= w_addr_next;
              r_state <= S_RD_REQ;
            end
          end else if (w_to_zero) begin
            r_state <= S_ABORT;
          end
        end
        S_ABORT: begin
          r_timeout  <= 1'b1;
          r_fail     <= 1'b1;
          r_err_addr <= r_addr;
          r_err_data <= '0;
          r_state    <= S_FINISH;
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i2c.i2c_trigger    = w_req;
  assign i2c.i2c_wl_rh      = r_wl_rh;
  assign i2c.i2c_addr_width = ADDR_16BIT;
  assign i2c.i2c_addr       = r_addr;
  assign i2c.i2c_wr_data    = r_wr_data;

  assign busy     = r_busy;
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign timeout  = r_timeout;
  assign err_addr = r_err_addr;
  assign err_data = r_err_data;

endmodule
`default_nettype wire

// File: tb/tb_e2prom_rw_ctrl.sv
`default_nettype none
// ============================================================================
// tb_e2prom_rw_ctrl : directed bench with i2c_dri behavioural models
// Rev 1.0
// ============================================================================
module tb_e2prom_rw_ctrl;

  localparam int LAT_A = 100;
  localparam int LAT_B = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A : START_ADDR 0x0010 ----------------
  logic        start_a = 1'b0;
  logic [7:0]  seed_a  = 8'h00;
  logic        busy_a, pass_a, fail_a, to_a;
  logic [15:0] eaddr_a;
  logic [7:0]  edata_a;
  e2prom_rw_ctrl_if bus_a ();

  e2prom_rw_ctrl #(
    .SYS_CLK(50_000_000), .BYTE_NUM(4), .START_ADDR(16'h0010), .ADDR_16BIT(1'b0),
    .WR_GAP_CYC(20), .TIMEOUT_CYC(500)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a), .seed(seed_a), .i2c(bus_a.master),
    .busy(busy_a), .pass(pass_a), .fail(fail_a), .timeout(to_a),
    .err_addr(eaddr_a), .err_data(edata_a)
  );

  // ---------------- instance B : START_ADDR 0xFFFE ----------------
  logic        start_b = 1'b0;
  logic [7:0]  seed_b  = 8'h00;
  logic        busy_b, pass_b, fail_b, to_b;
  logic [15:0] eaddr_b;
  logic [7:0]  edata_b;
  e2prom_rw_ctrl_if bus_b ();

  e2prom_rw_ctrl #(
    .SYS_CLK(50_000_000), .BYTE_NUM(4), .START_ADDR(16'hFFFE), .ADDR_16BIT(1'b1),
    .WR_GAP_CYC(20), .TIMEOUT_CYC(500)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b), .seed(seed_b), .i2c(bus_b.master),
    .busy(busy_b), .pass(pass_b), .fail(fail_b), .timeout(to_b),
    .err_addr(eaddr_b), .err_data(edata_b)
  );

  // ---------------- driver model A ----------------
  logic [7:0]  mem_a [0:255];
  logic [15:0] trig_addr_a [$];
  logic [7:0]  trig_data_a [$];
  logic        trig_rd_a   [$];
  int          cnt_a = 0, nwr_a = 0, hang_wr_a = 0, dbl_a = 0, hold_err_a = 0;
  logic        prev_trig_a = 1'b0, corrupt_en_a = 1'b0, inj_done_a = 1'b0;
  logic        op_rd_a = 1'b0, mdl_done_a = 1'b0;
  logic [15:0] op_addr_a = '0;
  logic [7:0]  op_data_a = '0, mdl_rd_a = '0;

  assign bus_a.i2c_done    = mdl_done_a | inj_done_a;
  assign bus_a.i2c_rd_data = mdl_rd_a;

  always @(posedge clk) begin
    mdl_done_a <= 1'b0;
    if (!rst_n) begin
      cnt_a = 0;
    end else if (bus_a.i2c_trigger) begin
      if (prev_trig_a) dbl_a++;
      trig_addr_a.push_back(bus_a.i2c_addr);
      trig_data_a.push_back(bus_a.i2c_wr_data);
      trig_rd_a.push_back(bus_a.i2c_wl_rh);
      op_rd_a   = bus_a.i2c_wl_rh;
      op_addr_a = bus_a.i2c_addr;
      op_data_a = bus_a.i2c_wr_data;
      if (!op_rd_a) nwr_a++;
      cnt_a = (!op_rd_a && nwr_a == hang_wr_a) ? 0 : LAT_A;
    end else if (cnt_a > 0) begin
      if (bus_a.i2c_addr !== op_addr_a || bus_a.i2c_wl_rh !== op_rd_a ||
          (!op_rd_a && bus_a.i2c_wr_data !== op_data_a)) hold_err_a++;
      cnt_a--;
      if (cnt_a == 0) begin
        mdl_done_a <= 1'b1;
        if (op_rd_a) mdl_rd_a <= (corrupt_en_a && op_addr_a == 16'h0012) ? 8'h00 : mem_a[op_addr_a[7:0]];
        else         mem_a[op_addr_a[7:0]] = op_data_a;
      end
    end
    prev_trig_a = bus_a.i2c_trigger;
  end

  // ---------------- driver model B ----------------
  logic [7:0]  mem_b [0:255];
  logic [15:0] trig_addr_b [$];
  logic [7:0]  trig_data_b [$];
  logic        trig_rd_b   [$];
  int          cnt_b = 0;
  logic        op_rd_b = 1'b0, mdl_done_b = 1'b0;
  logic [15:0] op_addr_b = '0;
  logic [7:0]  op_data_b = '0, mdl_rd_b = '0;

  assign bus_b.i2c_done    = mdl_done_b;
  assign bus_b.i2c_rd_data = mdl_rd_b;

  always @(posedge clk) begin
    mdl_done_b <= 1'b0;
    if (!rst_n) begin
      cnt_b = 0;
    end else if (bus_b.i2c_trigger) begin
      trig_addr_b.push_back(bus_b.i2c_addr);
      trig_data_b.push_back(bus_b.i2c_wr_data);
      trig_rd_b.push_back(bus_b.i2c_wl_rh);
      op_rd_b   = bus_b.i2c_wl_rh;
      op_addr_b = bus_b.i2c_addr;
      op_data_b = bus_b.i2c_wr_data;
      cnt_b     = LAT_B;
    end else if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) begin
        mdl_done_b <= 1'b1;
        if (op_rd_b) mdl_rd_b <= mem_b[op_addr_b[7:0]];
        else         mem_b[op_addr_b[7:0]] = op_data_b;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    trig_addr_a.delete(); trig_data_a.delete(); trig_rd_a.delete(); nwr_a = 0;
  endtask

  task automatic wait_ntrig_a(input int n, input int maxc, input string tag);
    int c = 0;
    while (trig_addr_a.size() < n && c < maxc) begin @(negedge clk); c++; end
    chk(tag, 64'(trig_addr_a.size() >= n), 64'd1);
  endtask

  task automatic wait_done_a(input int maxc, input string tag);
    int c = 0;
    do begin @(negedge clk); c++; end while (bus_a.i2c_done !== 1'b1 && c < maxc);
    chk(tag, 64'(bus_a.i2c_done), 64'd1);
  endtask

  task automatic wait_idle_a(input int maxc, input string tag);
    int c = 0;
    do begin @(negedge clk); c++; end while (busy_a !== 1'b0 && c < maxc);
    chk(tag, 64'(busy_a), 64'd0);
  endtask

  task automatic pulse_start_a(input logic [7:0] s);
    seed_a = s; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] ea;
    int c;

    repeat (3) @(negedge clk);
    chk("rst_a_outs", 64'({busy_a, pass_a, fail_a, to_a, eaddr_a, edata_a}), 64'd0);
    chk("rst_a_bus", 64'({bus_a.i2c_trigger, bus_a.i2c_wl_rh, bus_a.i2c_addr_width,
                          bus_a.i2c_addr, bus_a.i2c_wr_data}), 64'd0);
    chk("rst_b_awidth", 64'({bus_b.i2c_addr_width, bus_b.i2c_trigger, busy_b}), 64'b100);
    rst_n = 1'b1;
    @(negedge clk);

    // Run 1: full pass, plus ignored start/done while busy
    clear_a();
    pulse_start_a(8'hA0);
    chk("t1_first_trig", 64'({bus_a.i2c_trigger, bus_a.i2c_wl_rh, bus_a.i2c_addr, bus_a.i2c_wr_data, busy_a}),
        64'({1'b1, 1'b0, 16'h0010, 8'hA0, 1'b1}));
    @(negedge clk);
    chk("t1_trig_single", 64'(bus_a.i2c_trigger), 64'd0);
    wait_done_a(300, "t1_wr0_done");
    repeat (5) @(negedge clk);
    inj_done_a = 1'b1; seed_a = 8'hFF; start_a = 1'b1;
    @(negedge clk);
    inj_done_a = 1'b0; start_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_gap_ignored", 64'({busy_a, bus_a.i2c_trigger, 8'(trig_addr_a.size())}), 64'({1'b1, 1'b0, 8'd1}));
    wait_ntrig_a(8, 2000, "t1_ntrig");
    wait_done_a(300, "t1_last_done");
    @(negedge clk);
    chk("t1_result_d1", 64'({pass_a, fail_a, to_a, busy_a}), 64'b1001);
    @(negedge clk);
    chk("t1_busy_d2", 64'({pass_a, fail_a, busy_a}), 64'b100);
    chk("t1_ntrig_total", 64'(trig_addr_a.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      ea = 16'h0010 + 16'(i % 4);
      chk($sformatf("t1_op%0d", i),
          64'({trig_rd_a[i], trig_addr_a[i], trig_rd_a[i] ? 8'h00 : trig_data_a[i]}),
          64'({(i >= 4), ea, (i >= 4) ? 8'h00 : 8'(8'hA0 + i)}));
    end

    // Spurious done in IDLE
    inj_done_a = 1'b1;
    @(negedge clk);
    inj_done_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_idle_ignored", 64'({8'(trig_addr_a.size()), busy_a, pass_a, fail_a}), 64'({8'd8, 3'b010}));

    // Run 2: read mismatch at 0x12
    clear_a(); corrupt_en_a = 1'b1;
    pulse_start_a(8'h30);
    wait_idle_a(3000, "t2_idle");
    chk("t2_flags", 64'({pass_a, fail_a, to_a}), 64'b010);
    chk("t2_err", 64'({eaddr_a, edata_a}), 64'({16'h0012, 8'h00}));
    chk("t2_ntrig", 64'(trig_addr_a.size()), 64'd7);
    chk("t2_last_op", 64'({trig_rd_a[6], trig_addr_a[6]}), 64'({1'b1, 16'h0012}));
    corrupt_en_a = 1'b0;

    // Run 3: driver hangs on second write
    clear_a(); hang_wr_a = 2;
    pulse_start_a(8'h40);
    wait_ntrig_a(2, 600, "t3_ntrig2");
    repeat (400) @(negedge clk);
    chk("t3_not_yet", 64'({busy_a, to_a, fail_a}), 64'b100);
    wait_idle_a(300, "t3_idle");
    chk("t3_flags", 64'({pass_a, fail_a, to_a}), 64'b011);
    chk("t3_err", 64'({eaddr_a, edata_a}), 64'({16'h0011, 8'h00}));
    chk("t3_ntrig", 64'(trig_addr_a.size()), 64'd2);
    hang_wr_a = 0;

    // Run 5: reset during the write gap, then restart
    clear_a();
    pulse_start_a(8'h77);
    wait_done_a(300, "t5_wr0_done");
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", 64'({busy_a, bus_a.i2c_addr, bus_a.i2c_wr_data}), 64'({1'b1, 16'h0010, 8'h77}));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rst_outs", 64'({busy_a, pass_a, fail_a, to_a, eaddr_a, edata_a}), 64'd0);
    chk("t5_rst_bus", 64'({bus_a.i2c_trigger, bus_a.i2c_wl_rh, bus_a.i2c_addr, bus_a.i2c_wr_data}), 64'd0);
    @(negedge clk);
    clear_a();
    pulse_start_a(8'h55);
    chk("t5_restart", 64'({bus_a.i2c_trigger, bus_a.i2c_wl_rh, bus_a.i2c_addr, bus_a.i2c_wr_data}),
        64'({1'b1, 1'b0, 16'h0010, 8'h55}));
    wait_idle_a(3000, "t5_idle");
    chk("t5_flags", 64'({pass_a, fail_a, to_a, 8'(trig_addr_a.size())}), 64'({3'b100, 8'd8}));
    chk("a_no_double_trig", 64'(dbl_a), 64'd0);
    chk("a_hold_stable", 64'(hold_err_a), 64'd0);

    // Run 4: address wrap on instance B
    seed_b = 8'hC0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (busy_b !== 1'b0 && c < 3000);
    chk("t4_idle", 64'(busy_b), 64'd0);
    chk("t4_flags", 64'({pass_b, fail_b, to_b, 8'(trig_addr_b.size())}), 64'({3'b100, 8'd8}));
    for (int i = 0; i < 8; i++) begin
      ea = 16'hFFFE + 16'(i % 4);
      chk($sformatf("t4_op%0d", i),
          64'({trig_rd_b[i], trig_addr_b[i], trig_rd_b[i] ? 8'h00 : trig_data_b[i]}),
          64'({(i >= 4), ea, (i >= 4) ? 8'h00 : 8'(8'hC0 + i)}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
